// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
//
// Every operation takes the same number of cycles. start is sampled on edge
// E0 and goes through PREP (E1) and 32 CALC iterations (E2..E33). It ends
// with FIX (E34), which writes result and pulses done.
//
// Handshake: start is honoured only while busy=0. A start seen while busy=1
// is dropped and is not queued. busy stays high from the edge after start is
// accepted up to and including the cycle before done. done is high for one
// cycle. In that cycle the unit is already IDLE, so it can accept a new start.
//
// Ports:
//   clk        system clock, rising-edge
//   reset      synchronous, active-high; aborts any operation in flight
//   start      operation request
//   op         0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   operand_a  rs1 value
//   operand_b  ALU-source mux output (register or immediate)
//   result     registered result, held until the next completion or reset
//   busy       operation in flight
//   done       single-cycle completion pulse
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic            done
);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam int RW = XLEN + 1;   // remainder register width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        CALC = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t            state;
    logic [2:0]        op_r;
    logic [XLEN-1:0]   a_r;
    logic [XLEN-1:0]   b_r;
    logic [XLEN-1:0]   mag_a;       // multiplicand (multiply only)
    logic [XLEN-1:0]   mag_b;       // multiplier source / divisor
    logic              neg_res;
    logic [2*XLEN-1:0] prod;
    // Multiply: multiplier, shifted right. Divide: dividend in, quotient out,
    // shifted left.
    logic [XLEN-1:0]   shreg;
    logic [RW-1:0]     rem;
    logic [CNT_W-1:0]  count;

    // Decoding and sign handling for the latched operation.
    logic              is_div;
    logic              is_rem;
    logic              a_sign;
    logic              b_sign;
    logic [XLEN-1:0]   a_mag_c;
    logic [XLEN-1:0]   b_mag_c;

    always_comb begin
        is_div  = op_r[2];
        is_rem  = (op_r == OP_REM) || (op_r == OP_REMU);
        a_sign  = 1'b0;
        b_sign  = 1'b0;
        case (op_r)
            OP_MULH, OP_DIV, OP_REM: begin
                a_sign = a_r[XLEN-1];
                b_sign = b_r[XLEN-1];
            end
            OP_MULHSU: a_sign = a_r[XLEN-1];
            default: ;
        endcase
        a_mag_c = a_sign ? -a_r : a_r;
        b_mag_c = b_sign ? -b_r : b_r;
    end

    // One shift-add step. The carry out of the high half moves into the top
    // bit while the product shifts right.
    logic [XLEN:0] mul_sum;

    // One restoring-division step. The trial value includes the full 33-bit
    // remainder, so the compare is exact even when the divisor is close to
    // 2^32. The result of a successful subtract is always below the divisor.
    logic [XLEN+1:0] div_trial;
    logic            div_ge;
    logic [RW-1:0]   div_sub;

    always_comb begin
        mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (shreg[0] ? {1'b0, mag_a} : '0);
        div_trial = {rem, shreg[XLEN-1]};
        div_ge    = (div_trial >= {2'b00, mag_b});
        div_sub   = RW'(div_trial - {2'b00, mag_b});
    end

    // Sign fix-up and result selection. The divide-by-zero results are forced
    // here. The signed-overflow case needs no special handling: the plain
    // datapath already yields 0x80000000 and 0.
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic              b_zero;
    logic [XLEN-1:0]   fix_result;

    always_comb begin
        prod_fix   = neg_res ? -prod : prod;
        quo_fix    = neg_res ? -shreg : shreg;
        rem_fix    = neg_res ? -rem[XLEN-1:0] : rem[XLEN-1:0];
        b_zero     = (b_r == '0);
        fix_result = '0;
        case (op_r)
            OP_MUL:                        fix_result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               fix_result = b_zero ? '1 : quo_fix;
            default:                       fix_result = b_zero ? a_r : rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            result  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            count   <= '0;
            op_r    <= '0;
            a_r     <= '0;
            b_r     <= '0;
            mag_a   <= '0;
            mag_b   <= '0;
            neg_res <= 1'b0;
            prod    <= '0;
            shreg   <= '0;
            rem     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r  <= op;
                        a_r   <= operand_a;
                        b_r   <= operand_b;
                        busy  <= 1'b1;
                        state <= PREP;
                    end
                end
                PREP: begin
                    mag_a   <= a_mag_c;
                    mag_b   <= b_mag_c;
                    shreg   <= is_div ? a_mag_c : b_mag_c;
                    neg_res <= is_rem ? a_sign : (a_sign ^ b_sign);
                    prod    <= '0;
                    rem     <= '0;
                    count   <= '0;
                    state   <= CALC;
                end
                CALC: begin
                    count <= count + 1'b1;
                    if (!is_div) begin
                        prod  <= {mul_sum, prod[XLEN-1:1]};
                        shreg <= shreg >> 1;
                    end else if (div_ge) begin
                        rem   <= div_sub;
                        shreg <= {shreg[XLEN-2:0], 1'b1};
                    end else begin
                        rem   <= div_trial[RW-1:0];
                        shreg <= {shreg[XLEN-2:0], 1'b0};
                    end
                    if (count == CNT_W'(XLEN - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result <= fix_result;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit: directed, table-driven bench for muldiv_unit.
// The table holds the operation, both operands and a hand-computed result.
// Every entry also checks for the fixed 34-cycle latency, 34 busy cycles and
// a single-cycle done pulse. Hand-written sequences cover an ignored start,
// a back-to-back start in the done cycle, and reset in the middle of an
// operation.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam int LATENCY = 34;
    localparam int NVEC    = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] result;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .result    (result),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [NVEC];

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Call at the sample point just after the edge that accepted start.
    // Returns when done is seen or when the cycle budget runs out. If poke >= 0,
    // start is pulsed for one cycle, with other operands, once lat reaches poke.
    task automatic wait_done(input int poke, output logic [31:0] res,
                             output int lat, output int busy_n);
        lat    = 0;
        busy_n = busy ? 1 : 0;
        while (!done && lat < 100) begin
            if (lat == poke) begin
                start     = 1'b1;
                op        = OP_DIVU;
                operand_a = 32'd100;
                operand_b = 32'd7;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
            if (busy) busy_n++;
        end
        start = 1'b0;
        res   = result;
    endtask

    // After start is accepted, the operand inputs are changed to junk
    // (b=0 included), so a unit that does not latch them gives a wrong result.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int poke, output logic [31:0] res,
                          output int lat, output int busy_n);
        op        = o;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        operand_a = 32'hDEAD_BEEF;
        operand_b = 32'h0000_0000;
        op        = 3'(~o);
        wait_done(poke, res, lat, busy_n);
    endtask

    logic [31:0] res;
    int          lat;
    int          busy_n;
    int          done_n;

    initial begin
        vecs[0]  = '{"mul_7x6",          OP_MUL,    32'd7,        32'd6,        32'h0000_002A};
        vecs[1]  = '{"mul_neg3x5",       OP_MUL,    32'hFFFF_FFFD, 32'd5,       32'hFFFF_FFF1};
        vecs[2]  = '{"mulh_min_min",     OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[3]  = '{"mulh_neg3x5",      OP_MULH,   32'hFFFF_FFFD, 32'd5,       32'hFFFF_FFFF};
        vecs[4]  = '{"mulh_m1_m1",       OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[5]  = '{"mulhu_max_max",    OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[6]  = '{"mulhsu_m1_max",    OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[7]  = '{"mulhsu_2_max",     OP_MULHSU, 32'd2,        32'hFFFF_FFFF, 32'h0000_0001};
        vecs[8]  = '{"div_m7_2",         OP_DIV,    32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFD};
        vecs[9]  = '{"rem_m7_2",         OP_REM,    32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFF};
        vecs[10] = '{"div_7_m2",         OP_DIV,    32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD};
        vecs[11] = '{"rem_7_m2",         OP_REM,    32'd7,        32'hFFFF_FFFE, 32'h0000_0001};
        vecs[12] = '{"rem_m7_m2",        OP_REM,    32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        vecs[13] = '{"divu_5_0",         OP_DIVU,   32'd5,        32'd0,        32'hFFFF_FFFF};
        vecs[14] = '{"remu_5_0",         OP_REMU,   32'd5,        32'd0,        32'h0000_0005};
        vecs[15] = '{"div_min_0",        OP_DIV,    32'h8000_0000, 32'd0,       32'hFFFF_FFFF};
        vecs[16] = '{"rem_m7_0",         OP_REM,    32'hFFFF_FFF9, 32'd0,       32'hFFFF_FFF9};
        vecs[17] = '{"div_overflow",     OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[18] = '{"rem_overflow",     OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[19] = '{"remu_100_7",       OP_REMU,   32'd100,      32'd7,        32'h0000_0002};

        // Reset held for two cycles, then released.
        reset     = 1'b1;
        start     = 1'b0;
        op        = 3'd0;
        operand_a = 32'd0;
        operand_b = 32'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check("reset_result", result, 32'h0);
        check("reset_busy",   {31'b0, busy}, 32'h0);
        check("reset_done",   {31'b0, done}, 32'h0);

        // Table of vectors.
        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, res, lat, busy_n);
            check({vecs[i].name, "_result"}, res, vecs[i].exp);
            check({vecs[i].name, "_latency"}, 32'(lat), 32'(LATENCY));
            check({vecs[i].name, "_busy_cycles"}, 32'(busy_n), 32'(LATENCY));
            @(posedge clk); #1;
            check({vecs[i].name, "_done_drop"}, {31'b0, done}, 32'h0);
        end

        // A start pulsed 5 cycles into MUL 3*4 must be ignored.
        run_op(OP_MUL, 32'd3, 32'd4, 5, res, lat, busy_n);
        check("ignored_start_result", res, 32'd12);
        check("ignored_start_latency", 32'(lat), 32'(LATENCY));
        @(posedge clk); #1;
        check("ignored_start_idle", {31'b0, busy}, 32'h0);

        // A start in the done cycle is accepted at once.
        run_op(OP_MUL, 32'd7, 32'd6, -1, res, lat, busy_n);
        check("b2b_first_result", res, 32'h2A);
        run_op(OP_DIVU, 32'd100, 32'd7, -1, res, lat, busy_n);
        check("b2b_second_result", res, 32'd14);
        check("b2b_second_latency", 32'(lat), 32'(LATENCY));

        // Reset 10 cycles into DIVU 100/7 aborts the operation without a done pulse.
        op        = OP_DIVU;
        operand_a = 32'd100;
        operand_b = 32'd7;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy",   {31'b0, busy}, 32'h0);
        check("abort_result", result, 32'h0);
        check("abort_done",   {31'b0, done}, 32'h0);
        done_n = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done) done_n++;
        end
        check("abort_no_done", 32'(done_n), 32'h0);
        check("abort_still_idle", {31'b0, busy}, 32'h0);
        run_op(OP_DIVU, 32'd100, 32'd7, -1, res, lat, busy_n);
        check("after_abort_result", res, 32'd14);
        check("after_abort_latency", 32'(lat), 32'(LATENCY));

        // result holds between done pulses.
        repeat (5) @(posedge clk);
        #1 check("result_hold", result, 32'd14);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit for the execute stage.
- Sits directly downstream of the ALU-source mux and alongside the ALU.
- operand_a comes from register-file read port 1; operand_b comes from the ALU-source mux output (register or immediate).
- Fixed-latency start/busy/done handshake; the control unit stalls the PC while busy is high.

Parameters:
- XLEN, 32, operand and result width; only 32 is supported.
- CNT_W, 6, width of the iteration counter; must hold XLEN.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- operand_a  input  32  rs1 value.
- operand_b  input  32  ALU-source mux output.
- result  output  32  registered result; held until the next completion or reset.
- busy  output  1  high while an operation is in flight.
- done  output  1  single-cycle completion pulse.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - Reset forces state=IDLE, result=0, busy=0, done=0, counter=0.
  - Reset mid-operation aborts the operation; no done pulse; result=0.
- States: IDLE, PREP, CALC, FIX.
  - busy = (state != IDLE).
  - done is a registered signal, asserted for exactly one cycle on the FIX->IDLE edge.
- IDLE: if start=1 at edge E0, latch op, operand_a and operand_b; go to PREP.
  - Later changes on the operand inputs have no effect.
- PREP (edge E1):
  - Record the sign of each operand per op: MULH/DIV/REM both signed; MULHSU a signed, b unsigned; others unsigned.
  - Take the magnitudes.
  - Record the result sign: a_sign XOR b_sign for product/quotient; a_sign for remainder.
  - Clear the 64-bit accumulator; counter=0; go to CALC.
- CALC (edges E2..E33): exactly 32 iterations, counter increments each cycle, go to FIX after counter=31.
  - Multiply: shift-add over the multiplier LSB-first into the 64-bit product.
  - Divide: restoring division MSB-first, one quotient bit per cycle; the remainder register is 33 bits.
- FIX (edge E34):
  - Negate the 64-bit product, quotient or remainder if the recorded sign requires it.
  - Select the result: MUL = low 32; MULH/MULHSU/MULHU = high 32; DIV/DIVU = quotient; REM/REMU = remainder.
  - Write result, done=1, go to IDLE.
- Latency: done is visible 34 clocks after the edge that sampled start. Latency is fixed for all ops, including special cases.
- Divide by zero (operand_b=0), checked in FIX:
  - DIV/DIVU give 0xFFFFFFFF.
  - REM/REMU give operand_a unchanged.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM gives 0.
- start while busy=1 is ignored; no queueing.
- start=1 in the same cycle as done=1: state is IDLE, so the new operation is accepted; done drops next cycle.
- result does not change between done pulses.

Test Plan:
- Reset held 2 cycles, then released -> result=0, busy=0, done=0. MUL a=7, b=6 -> busy high for 34 cycles, done pulses once, result=0x0000002A.
- Multiply highs:
  - MULH a=b=0x80000000 -> 0x40000000.
  - MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- Signed divide: DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF.
- Divide by zero: DIVU a=5, b=0 -> 0xFFFFFFFF. REMU a=5, b=0 -> 5. Signed overflow: DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM -> 0. All with full 34-cycle latency.
- Ignored and back-to-back starts:
  - start pulsed again 5 cycles into MUL 3*4 with different operands -> ignored, result=12.
  - start asserted during the done cycle -> accepted; second result appears 34 cycles later.
- Reset asserted 10 cycles into DIVU 100/7 -> busy=0 and result=0 next cycle, no done pulse. A fresh DIVU 100/7 then yields 14.
